// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Captures one ALU result word plus its {N,Z,C,V} flags through a valid/ready
// handshake and shifts the frame out LSB first on a serial valid/ready link:
// data bits, then flag bits, then an optional even-parity bit.
// Optional feature macro: SERIALIZER_PARITY_EN (adds the PARITY state and
// the trailing parity bit).
module alu_result_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_flags,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int FW = WIDTH + 4;
    localparam int CW = $clog2(WIDTH + 5);

    // The counter runs across the whole frame, so phase boundaries are
    // absolute bit indices.
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_FLAG = CW'(WIDTH + 3);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, FLAGS, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, FLAGS} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   shift_reg;
    logic [CW-1:0]   cnt;
    logic            xfer;
    logic            load;
`ifdef SERIALIZER_PARITY_EN
    logic            parity;
`endif

    assign load = (state == IDLE) && in_valid;
    assign xfer = ser_valid && ser_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (xfer && (cnt == LAST_DATA)) begin
                    state_nxt = FLAGS;
                end
            end
            FLAGS: begin
                if (xfer && (cnt == LAST_FLAG)) begin
`ifdef SERIALIZER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                if (xfer) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture, shifting and bit counting
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt       <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity    <= 1'b0;
`endif
        end else if (load) begin
            shift_reg <= {in_flags, in_data};
            cnt       <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity    <= ^{in_flags, in_data};
`endif
        end else if (xfer && ((state == DATA) || (state == FLAGS))) begin
            shift_reg <= {1'b0, shift_reg[FW-1:1]};
            cnt       <= cnt + CW'(1);
        end
    end

    // Output decode from registered state and datapath only
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DATA: begin
                ser_valid = 1'b1;
                ser_out   = shift_reg[0];
            end
            FLAGS: begin
                ser_valid = 1'b1;
                ser_out   = shift_reg[0];
`ifndef SERIALIZER_PARITY_EN
                ser_last  = (cnt == LAST_FLAG);
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity;
                ser_last  = 1'b1;
            end
`endif
            default: begin
                in_ready = 1'b0;
                busy     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench for alu_result_serializer (WIDTH=8). Expected frame
// bits are pushed to a queue when a word is offered and popped as the DUT
// completes each serial handshake. Honours SERIALIZER_PARITY_EN.
module tb_alu_result_serializer;

    localparam int WIDTH = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int L = WIDTH + 5;
`else
    localparam int L = WIDTH + 4;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       in_flags;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    int   vectors;
    int   miscompares;

    alu_result_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flags  (in_flags),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the expected frame for one word from first principles.
    task automatic push_frame(input logic [WIDTH-1:0] d, input logic [3:0] f);
        logic bits [L];
        logic p;
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bits[i] = d[i];
            p = p ^ d[i];
        end
        for (int i = 0; i < 4; i++) begin
            bits[WIDTH+i] = f[i];
            p = p ^ f[i];
        end
`ifdef SERIALIZER_PARITY_EN
        bits[WIDTH+4] = p;
`endif
        for (int i = 0; i < L; i++) begin
            exp_t e;
            e.b    = bits[i];
            e.last = (i == L - 1);
            q.push_back(e);
        end
    endtask

    // Offer one word and leave the bench one cycle after the capture edge.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic [3:0] f);
        in_valid = 1'b1;
        in_data  = d;
        in_flags = f;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        if (in_ready) push_frame(d, f);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        vectors++;
        if (ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ser_valid: got %b expected 0", ser_valid);
        end
        vectors++;
        if (ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ser_out: got %b expected 0", ser_out);
        end
        vectors++;
        if (ser_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ser_last: got %b expected 0", ser_last);
        end
    endtask

    task automatic test_basic_frame();
        int cyc;
        int nvalid;
        cyc = 0;
        nvalid = 0;
        ser_ready = 1'b1;
        send_word(8'hA5, 4'b0010);
        vectors++;
        if (ser_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: ser_valid got %b expected 1", ser_valid);
        end
        while (q.size() > 0 && cyc < 200) begin
            if (ser_valid) begin
                nvalid++;
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL basic_bit%0d: out/last got %b%b expected %b%b",
                             nvalid - 1, ser_out, ser_last, q[0].b, q[0].last);
                end
                void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_timeout: %0d bits pending expected 0", q.size());
            q.delete();
        end
        vectors++;
        if (nvalid != L) begin
            miscompares++;
            $display("FAIL basic_length: got %0d valid cycles expected %0d", nvalid, L);
        end
        vectors++;
        if ({in_ready, busy, ser_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_return_idle: ready/busy/valid got %b%b%b expected 100",
                     in_ready, busy, ser_valid);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [3:0] pat;
        pat = 4'b1001;
        cyc = 0;
        ser_ready = 1'b1;
        send_word(8'h3C, 4'b1011);
        while (q.size() > 0 && cyc < 300) begin
            ser_ready = pat[cyc % 4];
            if (ser_valid) begin
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL bp_bit: out/last got %b%b expected %b%b (ready=%b, left=%0d)",
                             ser_out, ser_last, q[0].b, q[0].last, ser_ready, q.size());
                end
                if (ser_ready) void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        ser_ready = 1'b1;
        vectors++;
        if (q.size() != 0 || ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_complete: pending %0d ser_valid %b expected 0 0", q.size(), ser_valid);
            q.delete();
        end
    endtask

    task automatic test_busy_input();
        int cyc;
        cyc = 0;
        ser_ready = 1'b1;
        send_word(8'hA5, 4'b0010);
        while (q.size() > 0 && cyc < 200) begin
            if (cyc == 3) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
                in_flags = 4'hF;
                vectors++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_flags: ready/busy got %b%b expected 01", in_ready, busy);
                end
            end else begin
                in_valid = 1'b0;
            end
            if (ser_valid) begin
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL busy_bit: out/last got %b%b expected %b%b (left=%0d)",
                             ser_out, ser_last, q[0].b, q[0].last, q.size());
                end
                void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (q.size() != 0 || ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_complete: pending %0d ser_valid %b expected 0 0", q.size(), ser_valid);
            q.delete();
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc;
        int popped;
        cyc = 0;
        popped = 0;
        ser_ready = 1'b1;
        send_word(8'hA5, 4'b0010);
        while (popped < 6 && cyc < 100) begin
            if (ser_valid) begin
                vectors++;
                if (ser_out !== q[0].b) begin
                    miscompares++;
                    $display("FAIL midrst_pre_bit%0d: got %b expected %b", popped, ser_out, q[0].b);
                end
                void'(q.pop_front());
                popped++;
            end
            tick();
            cyc++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        vectors++;
        if ({in_ready, busy, ser_valid, ser_out, ser_last} !== 5'b10000) begin
            miscompares++;
            $display("FAIL midrst_idle: ready/busy/valid/out/last got %b%b%b%b%b expected 10000",
                     in_ready, busy, ser_valid, ser_out, ser_last);
        end
        tick();
        vectors++;
        if (ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_no_resume: ser_valid got %b expected 0", ser_valid);
        end
        send_word(8'h00, 4'b0100);
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            if (ser_valid) begin
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL midrst_new_bit: out/last got %b%b expected %b%b (left=%0d)",
                             ser_out, ser_last, q[0].b, q[0].last, q.size());
                end
                void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_timeout: %0d bits pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        cyc = 0;
        ser_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h01;
        in_flags  = 4'h0;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        push_frame(8'h01, 4'h0);
        tick();
        in_data = 8'h80;
        while (q.size() > 0 && cyc < 200) begin
            if (ser_valid) begin
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL b2b_first_bit: out/last got %b%b expected %b%b (left=%0d)",
                             ser_out, ser_last, q[0].b, q[0].last, q.size());
                end
                void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        vectors++;
        if (q.size() != 0 || in_ready !== 1'b1 || ser_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_bubble: pending %0d ready %b valid %b expected 0 1 0",
                     q.size(), in_ready, ser_valid);
            q.delete();
        end
        push_frame(8'h80, 4'h0);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (ser_valid !== 1'b1 || ser_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_start: valid/out got %b%b expected 10", ser_valid, ser_out);
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            if (ser_valid) begin
                vectors++;
                if ({ser_out, ser_last} !== {q[0].b, q[0].last}) begin
                    miscompares++;
                    $display("FAIL b2b_second_bit: out/last got %b%b expected %b%b (left=%0d)",
                             ser_out, ser_last, q[0].b, q[0].last, q.size());
                end
                void'(q.pop_front());
            end
            tick();
            cyc++;
        end
        vectors++;
        if (q.size() != 0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: pending %0d ready %b expected 0 1", q.size(), in_ready);
            q.delete();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_flags    = '0;
        ser_ready   = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_busy_input();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Parallel-to-serial transmitter for the ALU output path: it captures one ALU result word plus its four status flags through a valid/ready handshake, then shifts the frame out one bit per accepted transfer on a serial valid/ready link. It sits after the ALU result register and drives the serial result channel read by the board-level display/receiver logic. It is the readout counterpart of the ALU's capture registers: they store, this block drains.

## Interface
Parameters:
- WIDTH, 8, ALU result width in bits; legal range 2 to 32.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream offers in_data/in_flags.
- in_ready  output  1  block can accept a word (high only in IDLE).
- in_data  input  WIDTH  ALU result word.
- in_flags  input  4  ALU flags {N,Z,C,V}; in_flags[0] (V) is sent first.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid frame bit.
- ser_ready  input  1  downstream accepts the current bit.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state not IDLE).

## Operation
- Frame: in_data bits 0..WIDTH-1 (LSB first), then in_flags bits 0..3, then an optional parity bit (see Configuration). Frame length L = WIDTH+4 without parity, WIDTH+5 with parity.
- States: IDLE, DATA, FLAGS, PARITY (PARITY exists only when compiled in).
- IDLE: in_ready=1, ser_valid=0. On in_valid&&in_ready, latch in_data and in_flags into a WIDTH+4 bit shift register, clear the bit counter, go to DATA.
- DATA: ser_valid=1, ser_out=shift_reg[0]. On ser_valid&&ser_ready, shift right by one and increment the counter. After WIDTH transfers, go to FLAGS.
- FLAGS: same shifting. After 4 transfers, go to PARITY if enabled, otherwise IDLE.
- PARITY: ser_out=parity, ser_valid=1. On the handshake, go to IDLE.
- ser_last=1 only while the final frame bit is presented.
- Bit counter: width clog2(WIDTH+5); it wraps to 0 on every frame start. No other wrap occurs.
- in_valid while busy is ignored and has no side effects. Captured data stays stable for the whole frame regardless of in_data changes.
- ser_ready while ser_valid=0 has no effect.

## Timing
- Reset (rst=1 at an edge, from any state, including mid-frame): state becomes IDLE and the counter, shift register and parity are cleared. The partial frame is dropped and never resumed. Outputs after that edge:
  - ser_out=0, ser_valid=0, ser_last=0, busy=0, in_ready=1.
- Latency: ser_valid rises 1 cycle after the in_valid&&in_ready edge, with bit 0 presented.
- Each bit is held stable, with ser_valid high, until the edge where ser_ready=1. Minimum is 1 cycle per bit.
- Full-throughput frame: L cycles of ser_valid. in_ready returns 1 in the cycle after the last-bit handshake, giving a mandatory one-cycle bubble between frames.
- in_ready and busy are decoded from registered state only; there is no combinational path from ser_ready or in_valid to any output.
- ser_out, ser_valid and ser_last are glitch-free registered or state-decoded values.

## Configuration
- SERIALIZER_PARITY_EN defined: the PARITY state and the trailing bit are compiled in.
  - Parity bit = XOR of all WIDTH+4 frame bits (even parity).
  - Parity is accumulated as bits are shifted, or computed at load time.
  - L = WIDTH+5.
- Not defined: there is no PARITY state or parity logic, ser_last falls on flag bit 3, and L = WIDTH+4.

## Test plan
- Reset, then idle: after rst, in_ready=1, busy=0, ser_valid=0, ser_out=0, ser_last=0.
- Basic frame, WIDTH=8, in_data=0xA5, in_flags=4'b0010, ser_ready held 1:
  - ser_out sequence is 1,0,1,0,0,1,0,1, then 0,1,0,0.
  - With parity enabled, a 13th bit of 1 follows (popcount 5).
  - ser_last is high only on the final bit, and in_ready returns 1 the next cycle.
- Backpressure: toggle ser_ready 1,0,0,1,... during a frame. Each bit holds until accepted, and no bit is duplicated or skipped.
- Busy input: pulse in_valid with in_data=0xFF mid-frame. There is no capture and the original 0xA5 frame completes intact.
- Reset mid-frame: assert rst after bit 5 of the frame. Next cycle, IDLE outputs apply. A new word 0x00 with flags 4'b0100 then sends 8 zeros, then 0,0,1,0 (plus parity 1 if enabled).
- Back-to-back: hold in_valid=1 continuously with words 0x01 then 0x80. The frames are separated by exactly one bubble cycle, and the second frame starts with bit value 0.
